ingress_frame_arbiter: RTL and testbench
========================================

// Module: ingress_frame_arbiter
// PURPOSE
//  Shares the single header FIFO / payload FIFO pair in front of the MAC switch between four port RX FIFOs.
//  Round-robin arbitration, whole-frame granularity; one frame is forwarded at a time.
//  Splits each frame into a 114-bit header word {port[1:0], dst[47:0], src[47:0], type[15:0]} and a payload byte stream with delimiter.
//  Discards runt frames.
// PARAMETERS
//  MAX_FRAME_LEN  1514  max forwarded bytes incl. 14-byte header (used only with FRAME_LEN_LIMIT_EN)
//  DROP_CNT_W     16    width of saturating runt/truncation counter
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous reset, active-high
//  rx_dout       in   32   FWFT RX FIFO data, port i = [8i+7:8i]
//  rx_del        in   4    delimiter, high with the last byte of a frame (port i = bit i)
//  rx_empty      in   4    RX FIFO empty per port
//  rx_rden       out  4    RX FIFO pop, one-hot or zero
//  h_fifo_din    out  114  header word
//  h_fifo_wren   out  1    header FIFO write
//  h_fifo_afull  in   1    header FIFO almost full (>=2 free entries when deasserted)
//  b_fifo_din    out  8    payload byte
//  b_fifo_del_din out 1    payload delimiter, set on the last payload byte
//  b_fifo_wren   out  1    payload FIFO write
//  b_fifo_afull  in   1    payload FIFO almost full (>=2 free entries when deasserted)
//  grant         out  4    one-hot port currently owned, 0 when idle
//  drop_cnt      out  DROP_CNT_W  dropped/truncated frame count, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to S_IDLE; RR pointer = 0 (port 0 highest priority); drop_cnt = 0.
//    Reset mid-frame abandons the frame; downstream FIFOs are reset by the same system reset.
//  - Request of port i = ~rx_empty[i]. Arbitration starts from port (ptr); after a frame from port i completes
//    (forwarded, dropped or truncated), ptr <= i+1 mod 4.
//  - S_IDLE: when any request is present and both afull are low, latch winner into grant -> S_HDR (1 cycle arb latency).
//  - S_HDR: pop one byte/cycle while ~rx_empty[g]. rx_rden is combinational:
//    grant & state-active & ~rx_empty & ~h_fifo_afull & ~b_fifo_afull.
//    Bytes shift into the header register: byte0 -> dst[47:40] ... byte13 -> type[7:0].
//    rx_del seen on byte 0..13 -> runt: byte consumed, nothing written, drop_cnt++, -> S_END.
//    After byte 13 without del -> S_HWR.
//  - S_HWR: h_fifo_wren = 1 for exactly one cycle with h_fifo_din = {port idx, header}; -> S_PAY.
//    A frame of exactly 14 bytes is a runt (payload must be >=1 byte).
//  - S_PAY: each popped byte appears on b_fifo_din with b_fifo_wren = 1 on the next cycle (registered,
//    1-cycle latency); b_fifo_del_din = rx_del of that byte. After writing del -> S_END.
//  - Stall: rx_empty or either afull gates the pop; no write is issued in a cycle without a pop;
//    output data is held.
//  - S_END: grant <= 0, advance ptr, -> S_IDLE. Idle gap between frames >= 2 cycles.
//  - Header is written before any of its payload bytes; header/payload order is identical across FIFOs.
//  - drop_cnt saturates at all-ones; no wrap.
// CONFIGURATION
//  FRAME_LEN_LIMIT_EN defined:
//    - A byte counter (11 bits min) counts forwarded bytes.
//    - If byte MAX_FRAME_LEN is reached without del, that payload byte is written with b_fifo_del_din = 1,
//      drop_cnt++, and the FSM enters S_FLUSH.
//    - S_FLUSH: pop and discard port bytes (no writes, afull ignored) through the byte with rx_del, then S_END.
//  FRAME_LEN_LIMIT_EN undefined:
//    - No counter, no S_FLUSH; frames of any length are forwarded unchanged.
// TESTING
//  1. Port 2 frame: 14-byte header (dst 01:02:03:04:05:06, src 0A:..:0F, type 0800) + 46 bytes -> one h write
//     = {2'd2, dst, src, 16'h0800}; 46 b writes, del only on the 46th; grant = 4'b0100 during the frame.
//  2. All four ports hold 1 frame each, ptr = 0 -> service order 0,1,2,3; then a new frame on port 0
//     while port 3 refills -> port 0 served next.
//  3. Port 1 frame of 10 bytes with del on byte 10 -> no h/b writes, 10 pops, drop_cnt 0 -> 1.
//  4. b_fifo_afull held high for 5 cycles mid-payload -> rx_rden = 0 and b_fifo_wren = 0 for those cycles;
//     byte sequence intact afterwards.
//  5. rst asserted for 1 cycle during S_PAY -> next cycle all outputs 0, grant 0; next frame starts at port 0.
//  6. (FRAME_LEN_LIMIT_EN, MAX_FRAME_LEN = 64) 100-byte frame -> 50 b writes, del on the 50th;
//     remaining 36 bytes popped without writes; drop_cnt++.

Source files
------------

// File: rtl/ingress_frame_arbiter_if.sv
// ----------------------------------------------------------------------------
// ingress_frame_arbiter_if
// Bundles the four port RX FIFO read ports and the shared header/payload FIFO
// write ports used by ingress_frame_arbiter.
//   rx_dout[31:0]   FWFT RX data, port i on [8i+7:8i]
//   rx_del[3:0]     last-byte delimiter per port
//   rx_empty[3:0]   RX FIFO empty per port
//   rx_rden[3:0]    RX FIFO pop (one-hot or zero)
//   h_fifo_*        114-bit header word write port + almost-full
//   b_fifo_*        payload byte + delimiter write port + almost-full
// master = arbiter side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface ingress_frame_arbiter_if;
  logic [31:0]  rx_dout;
  logic [3:0]   rx_del;
  logic [3:0]   rx_empty;
  logic [3:0]   rx_rden;
  logic [113:0] h_fifo_din;
  logic         h_fifo_wren;
  logic         h_fifo_afull;
  logic [7:0]   b_fifo_din;
  logic         b_fifo_del_din;
  logic         b_fifo_wren;
  logic         b_fifo_afull;

  modport master (
    input  rx_dout, rx_del, rx_empty, h_fifo_afull, b_fifo_afull,
    output rx_rden, h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_del_din, b_fifo_wren
  );

  modport slave (
    output rx_dout, rx_del, rx_empty, h_fifo_afull, b_fifo_afull,
    input  rx_rden, h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_del_din, b_fifo_wren
  );
endinterface

// File: rtl/ingress_frame_arbiter.sv
// ----------------------------------------------------------------------------
// ingress_frame_arbiter
// Round-robin, whole-frame arbiter sharing one header FIFO / payload FIFO pair
// between four port RX FIFOs. Each frame is split into a 114-bit header word
// {port, dst, src, type} and a delimited payload byte stream; runts (<= 14
// bytes) are consumed and counted but never written downstream.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   bus         ingress_frame_arbiter_if.master (RX pops, header/payload writes)
//   grant       one-hot port currently owned, 0 when idle
//   drop_cnt    saturating count of dropped/truncated frames
// Optional feature macro: FRAME_LEN_LIMIT_EN -- truncates frames longer than
// MAX_FRAME_LEN bytes (header included) and flushes the remainder.
// ----------------------------------------------------------------------------
module ingress_frame_arbiter #(
  parameter int MAX_FRAME_LEN = 1514,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ingress_frame_arbiter_if.master bus,
  output logic [3:0]              grant,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

`ifdef FRAME_LEN_LIMIT_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWR, S_PAY, S_END, S_FLUSH} state_t;
  localparam int BCNT_W = ($clog2(MAX_FRAME_LEN + 1) > 11) ? $clog2(MAX_FRAME_LEN + 1) : 11;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(MAX_FRAME_LEN - 1);
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWR, S_PAY, S_END} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_grant, w_grant_nxt;
  logic [1:0]            r_gidx, w_gidx_nxt;
  logic [1:0]            r_ptr, w_ptr_nxt;
  logic [3:0]            r_hcnt, w_hcnt_nxt;
  logic [111:0]          r_hdr, w_hdr_nxt;
  logic [DROP_CNT_W-1:0] r_drop, w_drop_nxt;
  logic [7:0]            r_b_din_p1, w_b_din_nxt;
  logic                  r_b_del_p1, w_b_del_nxt;
  logic                  r_b_vld_p1, w_b_vld_nxt;

  logic [1:0] w_win_idx;
  logic       w_win_found;
  logic       w_space_ok;
  logic       w_pop;
  logic [7:0] w_byte;
  logic       w_del;
  logic       w_hwr;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin search starting at r_ptr; first non-empty port wins.
  always_comb begin
    w_win_idx   = r_ptr;
    w_win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_win_found && !bus.rx_empty[r_ptr + 2'(k)]) begin
        w_win_idx   = r_ptr + 2'(k);
        w_win_found = 1'b1;
      end
    end
  end

  assign w_space_ok = ~bus.h_fifo_afull & ~bus.b_fifo_afull;
  assign w_byte     = bus.rx_dout[{r_gidx, 3'b000} +: 8];
  assign w_del      = bus.rx_del[r_gidx];

  // Pop enable: forwarding states need downstream room, flushing does not.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_HDR, S_PAY: w_pop = ~bus.rx_empty[r_gidx] & w_space_ok;
`ifdef FRAME_LEN_LIMIT_EN
      S_FLUSH:      w_pop = ~bus.rx_empty[r_gidx];
`endif
      default:      w_pop = 1'b0;
    endcase
  end

  // Next-state / datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    w_hdr_nxt   = r_hdr;
    w_drop_nxt  = r_drop;
    w_b_vld_nxt = 1'b0;
    w_b_din_nxt = r_b_din_p1;
    w_b_del_nxt = r_b_del_p1;
`ifdef FRAME_LEN_LIMIT_EN
    w_bcnt_nxt  = r_bcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_win_found && w_space_ok) begin
          w_grant_nxt = 4'b0001 << w_win_idx;
          w_gidx_nxt  = w_win_idx;
          w_hcnt_nxt  = '0;
`ifdef FRAME_LEN_LIMIT_EN
          w_bcnt_nxt  = '0;
`endif
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (w_pop) begin
          // First byte ends up in dst[47:40], byte 13 in type[7:0].
          w_hdr_nxt  = {r_hdr[103:0], w_byte};
          w_hcnt_nxt = r_hcnt + 4'd1;
`ifdef FRAME_LEN_LIMIT_EN
          w_bcnt_nxt = r_bcnt + 1'b1;
`endif
          if (w_del) begin
            w_drop_nxt  = sat_inc(r_drop);
            w_state_nxt = S_END;
          end else if (r_hcnt == 4'd13) begin
            w_state_nxt = S_HWR;
          end
        end
      end
      S_HWR: w_state_nxt = S_PAY;
      S_PAY: begin
        if (w_pop) begin
          w_b_vld_nxt = 1'b1;
          w_b_din_nxt = w_byte;
          w_b_del_nxt = w_del;
`ifdef FRAME_LEN_LIMIT_EN
          w_bcnt_nxt  = r_bcnt + 1'b1;
`endif
          if (w_del) begin
            w_state_nxt = S_END;
`ifdef FRAME_LEN_LIMIT_EN
          end else if (r_bcnt == LAST_BYTE) begin
            // Truncate: close the forwarded frame here, discard the rest.
            w_b_del_nxt = 1'b1;
            w_drop_nxt  = sat_inc(r_drop);
            w_state_nxt = S_FLUSH;
`endif
          end
        end
      end
`ifdef FRAME_LEN_LIMIT_EN
      S_FLUSH: begin
        if (w_pop && w_del) w_state_nxt = S_END;
      end
`endif
      S_END: begin
        w_grant_nxt = '0;
        w_ptr_nxt   = r_gidx + 2'd1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control / output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_hcnt     <= '0;
      r_drop     <= '0;
      r_b_vld_p1 <= 1'b0;
      r_b_din_p1 <= '0;
      r_b_del_p1 <= 1'b0;
`ifdef FRAME_LEN_LIMIT_EN
      r_bcnt     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_drop     <= w_drop_nxt;
      r_b_vld_p1 <= w_b_vld_nxt;
      r_b_din_p1 <= w_b_din_nxt;
      r_b_del_p1 <= w_b_del_nxt;
`ifdef FRAME_LEN_LIMIT_EN
      r_bcnt     <= w_bcnt_nxt;
`endif
    end
  end

  // Header shift register: only observed while S_HWR, so it needs no reset.
  always_ff @(posedge clk) begin
    r_hdr <= w_hdr_nxt;
  end

  assign w_hwr              = (r_state == S_HWR);
  assign bus.rx_rden        = r_grant & {4{w_pop}};
  assign bus.h_fifo_wren    = w_hwr;
  assign bus.h_fifo_din     = w_hwr ? {r_gidx, r_hdr} : '0;
  assign bus.b_fifo_wren    = r_b_vld_p1;
  assign bus.b_fifo_din     = r_b_din_p1;
  assign bus.b_fifo_del_din = r_b_del_p1;
  assign grant              = r_grant;
  assign drop_cnt           = r_drop;

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ingress_frame_arbiter
// Directed bench: four FWFT RX FIFO models feed the arbiter; header and payload
// writes, grants and pops are logged and compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ingress_frame_arbiter;
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b1;
  always #5 clk = ~clk;

  ingress_frame_arbiter_if bus ();
  logic [3:0]  grant;
  logic [15:0] drop_cnt;

  ingress_frame_arbiter #(.MAX_FRAME_LEN(64), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant(grant), .drop_cnt(drop_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // RX FIFO models
  logic [7:0]  mem  [4][2048];
  logic        mdel [4][2048];
  logic [10:0] wrp  [4] = '{default: '0};
  logic [10:0] rdp  [4] = '{default: '0};
  int          popcnt [4] = '{default: 0};

  always_comb begin
    bus.rx_dout  = '0;
    bus.rx_del   = '0;
    bus.rx_empty = '0;
    for (int i = 0; i < 4; i++) begin
      bus.rx_dout[8*i +: 8] = mem[i][rdp[i]];
      bus.rx_del[i]         = mdel[i][rdp[i]];
      bus.rx_empty[i]       = (rdp[i] == wrp[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush) rdp[i] <= wrp[i];
      else if (bus.rx_rden[i] && (rdp[i] != wrp[i])) begin
        rdp[i]    <= rdp[i] + 11'd1;
        popcnt[i] <= popcnt[i] + 1;
      end
    end
  end

  // Output logs
  logic [113:0] hlog [64];
  int           hn = 0;
  logic [7:0]   blog [2048];
  logic         bdel [2048];
  int           bn = 0;
  logic [3:0]   glog [64];
  int           gn = 0;
  logic [3:0]   gprev = '0;

  always @(negedge clk) begin
    if (bus.h_fifo_wren && hn < 64) begin hlog[hn] = bus.h_fifo_din; hn++; end
    if (bus.b_fifo_wren && bn < 2048) begin
      blog[bn] = bus.b_fifo_din; bdel[bn] = bus.b_fifo_del_din; bn++;
    end
    if (grant != 4'b0 && gprev == 4'b0 && gn < 64) begin glog[gn] = grant; gn++; end
    gprev = grant;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input int p, input logic [7:0] b, input logic d);
    mem[p][wrp[p]]  = b;
    mdel[p][wrp[p]] = d;
    wrp[p]          = wrp[p] + 11'd1;
  endtask

  task automatic push_frame(input int p, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) push_byte(p, base + 8'(k), k == len - 1);
  endtask

  function automatic logic all_drained();
    for (int i = 0; i < 4; i++) if (rdp[i] != wrp[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string name, input int max);
    int c = 0;
    while (!(all_drained() && grant == 4'b0 && !bus.b_fifo_wren) && c < max) begin
      step(); c++;
    end
    repeat (2) step();
    n_cmp++;
    if (c >= max) begin
      n_fail++;
      $display("FAIL %s_done: still busy after %0d cycles, required idle within %0d", name, c, max);
    end
  endtask

  task automatic wait_bn(input string name, input int target, input int max);
    int c = 0;
    while (bn < target && c < max) begin step(); c++; end
    n_cmp++;
    if (bn < target) begin
      n_fail++;
      $display("FAIL %s_bwrites: got %0d, required >= %0d", name, bn, target);
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [15:0] exp_drop);
    n_cmp++; if (bus.rx_rden !== 4'b0) begin n_fail++; $display("FAIL %s_rden: got %b, required 0000", name, bus.rx_rden); end
    n_cmp++; if (bus.h_fifo_wren !== 1'b0) begin n_fail++; $display("FAIL %s_hwren: got %b, required 0", name, bus.h_fifo_wren); end
    n_cmp++; if (bus.h_fifo_din !== 114'b0) begin n_fail++; $display("FAIL %s_hdin: got %h, required 0", name, bus.h_fifo_din); end
    n_cmp++; if (bus.b_fifo_wren !== 1'b0) begin n_fail++; $display("FAIL %s_bwren: got %b, required 0", name, bus.b_fifo_wren); end
    n_cmp++; if (bus.b_fifo_din !== 8'h00 || bus.b_fifo_del_din !== 1'b0) begin
      n_fail++; $display("FAIL %s_bdin: got %h/%b, required 00/0", name, bus.b_fifo_din, bus.b_fifo_del_din); end
    n_cmp++; if (grant !== 4'b0) begin n_fail++; $display("FAIL %s_grant: got %b, required 0000", name, grant); end
    n_cmp++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL %s_drop: got %0d, required %0d", name, drop_cnt, exp_drop); end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1;
    repeat (3) step();
    rst = 1'b0; flush = 1'b0;
    step();
    check_idle_outputs("reset", 16'd0);
  endtask

  task automatic test_round_robin();
    int g0 = gn, h0 = hn, b0 = bn, c = 0;
    logic [3:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
    logic [1:0] exp_p [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    for (int p = 0; p < 4; p++) push_frame(p, 20, 8'(16 * p));
    while (grant != 4'b1000 && c < 400) begin step(); c++; end
    n_cmp++;
    if (grant != 4'b1000) begin n_fail++; $display("FAIL rr_port3_grant: got %b, required 1000", grant); end
    push_frame(0, 16, 8'h80);
    push_frame(3, 16, 8'h90);
    wait_done("rr", 600);
    n_cmp++; if (gn - g0 != 6) begin n_fail++; $display("FAIL rr_grant_count: got %0d, required 6", gn - g0); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (glog[g0 + k] !== exp_g[k]) begin n_fail++; $display("FAIL rr_order%0d: got %b, required %b", k, glog[g0 + k], exp_g[k]); end
      n_cmp++; if (hlog[h0 + k][113:112] !== exp_p[k]) begin n_fail++; $display("FAIL rr_hport%0d: got %0d, required %0d", k, hlog[h0 + k][113:112], exp_p[k]); end
    end
    n_cmp++; if (bn - b0 != 28) begin n_fail++; $display("FAIL rr_bcount: got %0d, required 28", bn - b0); end
  endtask

  task automatic test_runt();
    int h0 = hn, b0 = bn, p0 = popcnt[1];
    push_frame(1, 10, 8'h50);
    wait_done("runt10", 200);
    n_cmp++; if (hn != h0 || bn != b0) begin n_fail++; $display("FAIL runt10_writes: got h%0d b%0d, required 0 0", hn - h0, bn - b0); end
    n_cmp++; if (popcnt[1] - p0 != 10) begin n_fail++; $display("FAIL runt10_pops: got %0d, required 10", popcnt[1] - p0); end
    n_cmp++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL runt10_drop: got %0d, required 1", drop_cnt); end
    p0 = popcnt[1];
    push_frame(1, 14, 8'h60);
    wait_done("runt14", 200);
    n_cmp++; if (hn != h0 || bn != b0) begin n_fail++; $display("FAIL runt14_writes: got h%0d b%0d, required 0 0", hn - h0, bn - b0); end
    n_cmp++; if (popcnt[1] - p0 != 14) begin n_fail++; $display("FAIL runt14_pops: got %0d, required 14", popcnt[1] - p0); end
    n_cmp++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL runt14_drop: got %0d, required 2", drop_cnt); end
    push_frame(1, 15, 8'h70);
    wait_done("min15", 200);
    n_cmp++; if (hn - h0 != 1 || bn - b0 != 1) begin n_fail++; $display("FAIL min15_writes: got h%0d b%0d, required 1 1", hn - h0, bn - b0); end
    n_cmp++; if (blog[b0] !== 8'h7E || bdel[b0] !== 1'b1) begin n_fail++; $display("FAIL min15_byte: got %h/%b, required 7e/1", blog[b0], bdel[b0]); end
    n_cmp++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL min15_drop: got %0d, required 2", drop_cnt); end
  endtask

  task automatic test_port2_frame();
    int h0 = hn, b0 = bn, g0 = gn;
    logic [7:0] hb [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h08, 8'h00};
    logic [113:0] exp_h = {2'd2, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800};
    bus.h_fifo_afull = 1'b1;
    for (int k = 0; k < 14; k++) push_byte(2, hb[k], 1'b0);
    for (int k = 0; k < 46; k++) push_byte(2, 8'hC0 + 8'(k), k == 45);
    repeat (3) step();
    n_cmp++; if (grant !== 4'b0 || bus.rx_rden !== 4'b0) begin n_fail++; $display("FAIL afull_blocks_arb: got grant %b rden %b, required 0000 0000", grant, bus.rx_rden); end
    bus.h_fifo_afull = 1'b0;
    wait_done("p2", 300);
    n_cmp++; if (hn - h0 != 1) begin n_fail++; $display("FAIL p2_hcount: got %0d, required 1", hn - h0); end
    n_cmp++; if (hlog[h0] !== exp_h) begin n_fail++; $display("FAIL p2_header: got %h, required %h", hlog[h0], exp_h); end
    n_cmp++; if (bn - b0 != 46) begin n_fail++; $display("FAIL p2_bcount: got %0d, required 46", bn - b0); end
    for (int k = 0; k < 46; k++) begin
      n_cmp++;
      if (blog[b0 + k] !== 8'hC0 + 8'(k) || bdel[b0 + k] !== (k == 45)) begin
        n_fail++; $display("FAIL p2_byte%0d: got %h/%b, required %h/%b", k, blog[b0 + k], bdel[b0 + k], 8'hC0 + 8'(k), k == 45);
      end
    end
    n_cmp++; if (gn - g0 != 1 || glog[g0] !== 4'b0100) begin n_fail++; $display("FAIL p2_grant: got %b (n=%0d), required 0100 (n=1)", glog[g0], gn - g0); end
  endtask

  task automatic test_backpressure();
    int h0 = hn, b0 = bn;
    push_frame(0, 44, 8'h20);
    wait_bn("bp_start", b0 + 10, 200);
    bus.b_fifo_afull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (bus.rx_rden !== 4'b0 || bus.b_fifo_wren !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall%0d: got rden %b wren %b, required 0000 0", k, bus.rx_rden, bus.b_fifo_wren);
      end
    end
    bus.b_fifo_afull = 1'b0;
    wait_done("bp", 300);
    n_cmp++; if (hn - h0 != 1 || bn - b0 != 30) begin n_fail++; $display("FAIL bp_counts: got h%0d b%0d, required 1 30", hn - h0, bn - b0); end
    for (int k = 0; k < 30; k++) begin
      n_cmp++;
      if (blog[b0 + k] !== 8'h2E + 8'(k) || bdel[b0 + k] !== (k == 29)) begin
        n_fail++; $display("FAIL bp_byte%0d: got %h/%b, required %h/%b", k, blog[b0 + k], bdel[b0 + k], 8'h2E + 8'(k), k == 29);
      end
    end
  endtask

  task automatic test_long_frame();
    int h0 = hn, b0 = bn, p0 = popcnt[1];
`ifdef FRAME_LEN_LIMIT_EN
    int exp_b = 50; logic [15:0] exp_drop = 16'd3;
`else
    int exp_b = 86; logic [15:0] exp_drop = 16'd2;
`endif
    push_frame(1, 100, 8'h00);
    wait_done("long", 400);
    n_cmp++; if (hn - h0 != 1 || bn - b0 != exp_b) begin n_fail++; $display("FAIL long_counts: got h%0d b%0d, required 1 %0d", hn - h0, bn - b0, exp_b); end
    for (int k = 0; k < exp_b; k++) begin
      n_cmp++;
      if (blog[b0 + k] !== 8'(14 + k) || bdel[b0 + k] !== (k == exp_b - 1)) begin
        n_fail++; $display("FAIL long_byte%0d: got %h/%b, required %h/%b", k, blog[b0 + k], bdel[b0 + k], 8'(14 + k), k == exp_b - 1);
      end
    end
    n_cmp++; if (popcnt[1] - p0 != 100) begin n_fail++; $display("FAIL long_pops: got %0d, required 100", popcnt[1] - p0); end
    n_cmp++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL long_drop: got %0d, required %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_reset_mid_frame();
    int b0 = bn, h0, g0;
    push_frame(3, 54, 8'h40);
    wait_bn("rstmid_start", b0 + 5, 200);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0;
    check_idle_outputs("rstmid", 16'd0);
    h0 = hn; g0 = gn;
    push_frame(2, 16, 8'hA0);
    push_frame(0, 16, 8'hB0);
    wait_done("rstmid", 300);
    n_cmp++; if (gn - g0 != 2 || glog[g0] !== 4'b0001 || glog[g0 + 1] !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_order: got %b,%b (n=%0d), required 0001,0100 (n=2)", glog[g0], glog[g0 + 1], gn - g0);
    end
    n_cmp++; if (hlog[h0][113:112] !== 2'd0) begin n_fail++; $display("FAIL rstmid_hport: got %0d, required 0", hlog[h0][113:112]); end
  endtask

  initial begin
    bus.h_fifo_afull = 1'b0;
    bus.b_fifo_afull = 1'b0;
    test_reset();
    test_round_robin();
    test_runt();
    test_port2_frame();
    test_backpressure();
    test_long_frame();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion earlier");
    $fatal(1, "watchdog");
  end
endmodule
